hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Issue-stage interlock controller for the 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
- The pipeline has no forwarding, so this block tracks destination registers of instructions in flight in ID/EX, EX/MEM and MEM/WB.
- It stalls the instruction in ID (holds IF/ID, injects a bubble into ID/EX) until its source operands have been written back.
- It also counts stall cycles for performance monitoring.

Parameters:
- DEPTH, 3, number of tracked in-flight stages after ID (ID/EX, EX/MEM, MEM/WB).
- WB_BYPASS, 0, 1 = register file writes through in the same cycle, so the oldest entry (MEM/WB) is excluded from hazard checks.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- id_valid  input  1  valid instruction present in ID.
- id_rs1  input  5  source register 1 of the ID instruction.
- id_rs2  input  5  source register 2 of the ID instruction.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- id_rd  input  5  destination register of the ID instruction.
- id_reg_write  input  1  ID instruction writes rd.
- flush  input  1  squash the ID instruction and the ID/EX entry (branch redirect).
- id_ready  output  1  ID instruction may advance this cycle; 0 = hold IF/ID.
- issue  output  1  ID instruction enters ID/EX at the next edge.
- bubble  output  1  inject NOP into ID/EX (reg_write=0) at the next edge.
- busy  output  1  any tracked entry valid.
- stall_count  output  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard: entries e[0..DEPTH-1], each {v, rd}. e[0] mirrors ID/EX; e[DEPTH-1] mirrors MEM/WB.
- Checked set: e[0..DEPTH-1-WB_BYPASS].
- match(r) = r != 0 and some checked entry has v=1 and rd == r.
- hazard = id_valid & ((id_uses_rs1 & match(id_rs1)) | (id_uses_rs2 & match(id_rs2))). This is combinational from the current state and inputs.
- id_ready = ~hazard. A hazard in the same cycle as flush is ignored (flush dominates).
- issue = id_valid & ~hazard & ~flush.
- bubble = ~issue. Any cycle without issue inserts a NOP.
- Each rising edge (not reset):
  - e[k+1] <= e[k] for k = 0..DEPTH-2.
  - e[0] <= issue ? {id_reg_write & (id_rd != 0), id_rd} : {0, 0}.
- flush: in addition to the above, e[1] <= {0, 0}, squashing the instruction leaving ID/EX. Older entries shift normally.
- Writes to x0 never create an entry. Reads of x0 never hazard.
- busy = OR of all e[k].v.
- stall_count increments by 1 on each edge where hazard & ~flush. It holds at 2^CNT_W-1 (no wrap).
- Reset values (next edge with rst=1): all e[k] = {0, 0}, stall_count = 0. This gives busy = 0, and id_ready = 1 regardless of inputs.
- Reset dominates flush and issue, including reset asserted mid-stall. The first cycle after reset has no hazards.
- Latency: a dependent instruction directly behind its producer waits DEPTH-WB_BYPASS cycles (3 by default). With one independent instruction between them it waits DEPTH-WB_BYPASS-1 cycles.
- Outputs other than stall_count and busy are combinational. No combinational path exists from flush to id_ready.

Test Plan:
- Reset, then issue "add x5,x1,x2" followed immediately by "sub x6,x5,x3" -> sub sees id_ready=0 and bubble=1 for 3 cycles, issue=1 in the 4th; stall_count=3.
- Same sequence with WB_BYPASS=1 -> 2 stall cycles; stall_count=2.
- Producer writes x0, consumer reads x0 -> no stall; e[0].v=0 after issue.
- Dependent pair with flush asserted in the consumer's first stall cycle -> issue=0 that cycle, e[1] cleared. A following consumer of x5 issues with no stall, and stall_count does not increment in the flush cycle.
- Parameter CNT_W=4, force 20 consecutive hazard cycles -> stall_count saturates at 15.
- Assert rst during the 2nd stall cycle -> next cycle busy=0, id_ready=1, stall_count=0; the held consumer issues immediately.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Issue-stage interface between the ID stage and the hazard scoreboard.
// The ID stage (master) drives the decoded instruction and flush; the scoreboard answers.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             flush;
  logic             id_ready;
  logic             issue;
  logic             bubble;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, flush,
    input  id_ready, issue, bubble, busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, flush,
    output id_ready, issue, bubble, busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Interlock for a no-forwarding 5-stage pipeline: tracks in-flight destination registers
// and holds the ID instruction until its sources have been written back.
module hazard_scoreboard #(
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   bus
);
  // With a write-through register file the MEM/WB entry can be read in the same cycle.
  localparam int CHK = DEPTH - WB_BYPASS;

  logic [DEPTH-1:0] r_v;
  logic [4:0]       r_rd [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic w_match1;
  logic w_match2;
  logic w_hazard;
  logic w_issue;

  always_comb begin
    w_match1 = 1'b0;
    w_match2 = 1'b0;
    for (int k = 0; k < CHK; k++) begin
      if (r_v[k] && (r_rd[k] == bus.id_rs1) && (bus.id_rs1 != 5'd0)) w_match1 = 1'b1;
      if (r_v[k] && (r_rd[k] == bus.id_rs2) && (bus.id_rs2 != 5'd0)) w_match2 = 1'b1;
    end
  end

  // id_ready deliberately ignores flush so there is no flush-to-ready path.
  assign w_hazard = bus.id_valid & ((bus.id_uses_rs1 & w_match1) | (bus.id_uses_rs2 & w_match2));
  assign w_issue  = bus.id_valid & ~w_hazard & ~bus.flush;

  assign bus.id_ready    = ~w_hazard;
  assign bus.issue       = w_issue;
  assign bus.bubble      = ~w_issue;
  assign bus.busy        = |r_v;
  assign bus.stall_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= '0;
      r_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) r_rd[k] <= 5'd0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]  <= r_v[k-1];
        r_rd[k] <= r_rd[k-1];
      end
      r_v[0]  <= w_issue & bus.id_reg_write & (bus.id_rd != 5'd0);
      r_rd[0] <= w_issue ? bus.id_rd : 5'd0;
      // A redirect squashes the instruction leaving ID/EX before it reaches EX/MEM.
      if (bus.flush && (DEPTH > 1)) begin
        r_v[1]  <= 1'b0;
        r_rd[1] <= 5'd0;
      end
      if (w_hazard && !bus.flush && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (default, write-through WB, 4-bit counter)
// share one stimulus set; sel chooses which instance receives a valid instruction.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int   sel;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  hazard_scoreboard_if #(.CNT_W(16)) if_a ();
  hazard_scoreboard_if #(.CNT_W(16)) if_b ();
  hazard_scoreboard_if #(.CNT_W(4))  if_c ();

  assign if_a.id_valid = id_valid & (sel == 0);
  assign if_b.id_valid = id_valid & (sel == 1);
  assign if_c.id_valid = id_valid & (sel == 2);
  assign if_a.flush = flush & (sel == 0);
  assign if_b.flush = flush & (sel == 1);
  assign if_c.flush = flush & (sel == 2);
  assign if_a.id_rs1 = id_rs1;       assign if_b.id_rs1 = id_rs1;       assign if_c.id_rs1 = id_rs1;
  assign if_a.id_rs2 = id_rs2;       assign if_b.id_rs2 = id_rs2;       assign if_c.id_rs2 = id_rs2;
  assign if_a.id_rd  = id_rd;        assign if_b.id_rd  = id_rd;        assign if_c.id_rd  = id_rd;
  assign if_a.id_uses_rs1 = id_uses_rs1; assign if_b.id_uses_rs1 = id_uses_rs1; assign if_c.id_uses_rs1 = id_uses_rs1;
  assign if_a.id_uses_rs2 = id_uses_rs2; assign if_b.id_uses_rs2 = id_uses_rs2; assign if_c.id_uses_rs2 = id_uses_rs2;
  assign if_a.id_reg_write = id_reg_write; assign if_b.id_reg_write = id_reg_write; assign if_c.id_reg_write = id_reg_write;

  hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(0), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(0), .CNT_W(4))  dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic        w_ready, w_issue, w_bubble, w_busy;
  logic [15:0] w_sc;
  assign w_ready  = (sel == 0) ? if_a.id_ready : (sel == 1) ? if_b.id_ready : if_c.id_ready;
  assign w_issue  = (sel == 0) ? if_a.issue    : (sel == 1) ? if_b.issue    : if_c.issue;
  assign w_bubble = (sel == 0) ? if_a.bubble   : (sel == 1) ? if_b.bubble   : if_c.bubble;
  assign w_busy   = (sel == 0) ? if_a.busy     : (sel == 1) ? if_b.busy     : if_c.busy;
  assign w_sc     = (sel == 0) ? if_a.stall_count : (sel == 1) ? if_b.stall_count : {12'd0, if_c.stall_count};

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int s);
    sel = s;
    rst = 1'b1;
    id_valid = 1'b0;
    flush = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("rst_busy", w_busy, 0);
    check("rst_ready", w_ready, 1);
    check("rst_count", w_sc, 0);
  endtask

  // Present one instruction, push its expected stall count, and hold it until issue.
  task automatic run_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                           input logic u2, input logic [4:0] rd, input logic rw, input int exp_stall);
    int  stalls;
    logic done;
    exp_q.push_back(exp_stall[7:0]);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; flush = 1'b0;
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (w_issue) begin
        check("stall_cycles", stalls, exp_q.pop_front());
        check("bubble_on_issue", w_bubble, 0);
        done = 1'b1;
      end else begin
        check("stall_ready_bubble", {w_ready, w_bubble}, 2'b01);
        stalls++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("issue_timeout", done, 1);
    if (!done) void'(exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int stalls_exp;
    int total;
    sel = 0; rst = 1'b1; flush = 1'b0; id_valid = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_reg_write = 1'b0;
    @(negedge clk);

    // add x5,x1,x2 ; sub x6,x5,x3 back to back
    do_reset(0);
    run_instr(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    run_instr(5'd5, 5'd3, 1, 1, 5'd6, 1, 3);
    idle(4);
    #1;
    check("dep_count", w_sc, 3);
    check("drain_busy", w_busy, 0);

    // Same pair with write-through register file
    do_reset(1);
    run_instr(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    run_instr(5'd5, 5'd3, 1, 1, 5'd6, 1, 2);
    idle(1);
    #1;
    check("bypass_count", w_sc, 2);

    // x0 never tracked and never hazards
    do_reset(0);
    run_instr(5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
    #1;
    check("x0_no_entry", w_busy, 0);
    run_instr(5'd0, 5'd0, 1, 1, 5'd7, 1, 0);
    idle(1);
    #1;
    check("x0_count", w_sc, 0);

    // Flush in the consumer's first stall cycle squashes the producer
    do_reset(0);
    run_instr(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd3; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    id_rd = 5'd6; id_reg_write = 1'b1; flush = 1'b1;
    #1;
    check("flush_issue", w_issue, 0);
    check("flush_ready", w_ready, 0);
    check("flush_bubble", w_bubble, 1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_cleared", w_busy, 0);
    check("flush_no_count", w_sc, 0);
    run_instr(5'd5, 5'd3, 1, 1, 5'd6, 1, 0);

    // Saturation of a 4-bit counter over 21 hazard cycles
    do_reset(2);
    for (int k = 1; k <= 7; k++) begin
      run_instr(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
      run_instr(5'd5, 5'd3, 1, 1, 5'd6, 1, 3);
      #1;
      check("sat_count", w_sc, (3 * k > 15) ? 15 : 3 * k);
    end

    // Reset asserted during the second stall cycle
    do_reset(0);
    run_instr(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd3; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
    id_rd = 5'd6; id_reg_write = 1'b1;
    #1;
    check("pre_rst_stall", w_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", w_busy, 0);
    check("mid_rst_ready", w_ready, 1);
    check("mid_rst_count", w_sc, 0);
    check("mid_rst_issue", w_issue, 1);
    @(posedge clk);
    @(negedge clk);
    id_valid = 1'b0;
    #1;
    check("mid_rst_tracked", w_busy, 1);

    // Random producer / filler gap / consumer distances
    do_reset(0);
    total = 0;
    for (int n = 0; n < 8; n++) begin
      logic [4:0] prd;
      int gap;
      prd = 5'($urandom_range(10, 20));
      gap = $urandom_range(0, 3);
      run_instr(5'd1, 5'd2, 1, 1, prd, 1, 0);
      for (int g = 0; g < gap; g++) run_instr(5'd1, 5'd2, 1, 0, 5'd9, 0, 0);
      stalls_exp = 3 - gap;
      total = total + stalls_exp;
      if ($urandom_range(0, 1) == 1)
        run_instr(5'd3, prd, 0, 1, 5'd0, 0, stalls_exp);
      else
        run_instr(prd, 5'd4, 1, 1, 5'd0, 0, stalls_exp);
    end
    #1;
    check("rand_count", w_sc, total);
    check("queue_empty", exp_q.size(), 0);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
